mfp_adc_max10_scanner: RTL and testbench
========================================

# mfp_adc_max10_scanner

Autonomous scan sequencer between the MAX10 modular ADC IP and the MIPSfpga peripheral side. It issues single-sample conversion commands over the ADC command interface (ADC_C_*) for every enabled channel. It captures the matching responses (ADC_R_*) into a per-channel result bank that the AHB-Lite ADC peripheral reads. It runs on the system clock and is instantiated inside the MFP_USE_ADC_MAX10 build.

## Interface
Parameters:
- CH_FIRST, 1: ADC channel number of bank slot 0; slot i maps to channel CH_FIRST+i.
- SCAN_PERIOD, 5000: idle cycles inserted before every scan, 1..2^20-1.
- RESP_TIMEOUT, 1023: maximum cycles to wait for a response before abandoning a conversion.

Ports (clock and reset first):
- HCLK  in  1  system clock, same clock as the ADC IP clock_clk.
- HRESETn  in  1  asynchronous active-low reset.
- ENABLE  in  1  run scanning.
- CH_MASK  in  8  bit i enables slot i.
- ADC_C_Valid  out  1  command valid.
- ADC_C_Channel  out  5  command channel.
- ADC_C_SOP  out  1  equals ADC_C_Valid.
- ADC_C_EOP  out  1  equals ADC_C_Valid.
- ADC_C_Ready  in  1  command accepted.
- ADC_R_Valid  in  1  response valid.
- ADC_R_Channel  in  5  response channel.
- ADC_R_Data  in  12  response sample.
- ADC_R_SOP, ADC_R_EOP  in  1  ignored.
- RD_INDEX  in  3  bank slot select.
- RD_DATA  out  12  combinational read of slot RD_INDEX.
- UPDATED  out  8  sticky per-slot "new result" flags.
- CLR_UPDATED  in  8  one-cycle clear strobes for UPDATED.
- SCAN_DONE  out  1  one-cycle pulse at the end of each scan.
- TIMEOUT_ERR  out  1  sticky; set on any response timeout; cleared only by reset.

## Operation
- States: IDLE, WAIT, SELECT, CMD, RESP, DONE.
- IDLE: enter WAIT when ENABLE=1.
- WAIT: count SCAN_PERIOD cycles, then go to SELECT with slot pointer 0. If ENABLE=0, return to IDLE.
- SELECT: advance the pointer to the next slot with its CH_MASK bit set, sampling CH_MASK at that moment, one slot per cycle.
  - Enabled slot found: go to CMD.
  - Pointer passes slot 7: go to DONE.
- CMD: hold ADC_C_Valid=1 and ADC_C_Channel=CH_FIRST+slot until ADC_C_Ready=1. Valid and channel must not change or drop before acceptance, even if ENABLE falls. On acceptance, go to RESP and clear the timeout counter.
- RESP: only one command is outstanding at a time.
  - ADC_R_Valid=1 with ADC_R_Channel inside CH_FIRST..CH_FIRST+7: write ADC_R_Data to that slot, set its UPDATED bit, then go to SELECT with the pointer incremented.
  - ADC_R_Valid=1 with an out-of-range channel: response dropped; keep waiting.
  - Counter reaches RESP_TIMEOUT: set TIMEOUT_ERR, leave the slot unchanged, go to SELECT.
- DONE: pulse SCAN_DONE. Go to WAIT if ENABLE=1, otherwise to IDLE.
- CH_MASK=0: every scan passes through SELECT into DONE without issuing any command; SCAN_DONE still pulses.
- UPDATED: a set and a clear on the same bit in the same cycle resolve to set.
- ENABLE low mid-scan: finish the current CMD/RESP, then go to DONE. Slots not yet converted keep their old values.

## Timing
- Reset values: ADC_C_Valid 0, ADC_C_Channel 0, SOP/EOP 0, all bank slots 0, UPDATED 0, SCAN_DONE 0, TIMEOUT_ERR 0, state IDLE.
- The ADC_C_* outputs are registered.
- ADC_C_Valid rises 1 cycle after SELECT finds a slot.
- A response is written into the bank on the cycle it is accepted. RD_DATA and UPDATED show it on the next cycle.
- ENABLE 0->1 to first ADC_C_Valid: SCAN_PERIOD+2 cycles minimum, plus one cycle per skipped slot.
- Timeout fires exactly RESP_TIMEOUT cycles after command acceptance.

## Configuration
- MFP_ADC_MAX10_AVERAGE_EN defined:
  - Each enabled slot is converted 4 times back to back (4 CMD/RESP pairs) per scan.
  - Samples are accumulated in a 14-bit sum; the stored value is sum[13:2].
  - UPDATED is set once, after the 4th sample.
  - A timeout on any of the 4 samples discards the partial sum for that slot.
- Undefined: one conversion per slot per scan; the raw sample is stored.

## Test plan
- Reset, then CH_MASK=8'h05, ENABLE=1, SCAN_PERIOD=4, ADC BFM with Ready immediate and response after 3 cycles -> commands on channels 1 then 3, slots 0 and 2 loaded, UPDATED=8'h05, one SCAN_DONE pulse per scan.
- BFM holds Ready low for 10 cycles -> ADC_C_Valid and channel stable for all 10 cycles, exactly one command accepted.
- BFM never responds, RESP_TIMEOUT=16 -> TIMEOUT_ERR set 16 cycles after acceptance, slot unchanged, scan continues to the next slot.
- CLR_UPDATED[0] pulsed in the same cycle that slot 0 is written -> UPDATED[0] remains 1.
- ENABLE dropped while in CMD -> command still completes and its response is stored, then SCAN_DONE, then IDLE with no further commands.
- With MFP_ADC_MAX10_AVERAGE_EN, samples 100, 101, 102, 103 on channel 1 -> slot 0 = 101, 4 commands issued.

Source files
------------

// File: rtl/mfp_adc_max10_scanner_if.sv
// rtl/mfp_adc_max10_scanner_if.sv - MAX10 modular ADC command/response channel bundle
//
// Purpose: groups the ADC IP command (ADC_C_*) and response (ADC_R_*) streams.
// Modports:
//   master - scan sequencer side: drives the command, receives Ready and responses.
//   slave  - ADC IP side: receives the command, drives Ready and responses.
// Signals:
//   ADC_C_Valid/Channel[4:0]/SOP/EOP  command from sequencer
//   ADC_C_Ready                       command accepted by the ADC
//   ADC_R_Valid/Channel[4:0]/Data[11:0]/SOP/EOP  conversion response

interface mfp_adc_max10_scanner_if;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;
  logic        ADC_R_SOP;
  logic        ADC_R_EOP;

  modport master (
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready,
    input  ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
  );

  modport slave (
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready,
    output ADC_R_Valid, ADC_R_Channel, ADC_R_Data, ADC_R_SOP, ADC_R_EOP
  );
endinterface

// File: rtl/mfp_adc_max10_scanner.sv
// rtl/mfp_adc_max10_scanner.sv - autonomous MAX10 ADC scan sequencer with per-channel result bank
//
// Purpose: waits SCAN_PERIOD cycles, then issues one single-sample conversion per
// enabled slot (slot i = ADC channel CH_FIRST+i), stores each response in an
// 8-entry result bank and flags it in UPDATED.
// Optional feature: define MFP_ADC_MAX10_AVERAGE_EN to convert each enabled slot
// four times per scan and store the 4-sample average.
// Ports:
//   HCLK, HRESETn         clock, asynchronous active-low reset
//   ENABLE                run scanning
//   CH_MASK[7:0]          per-slot enable
//   adc                   ADC command/response bundle (master modport)
//   RD_INDEX[2:0]         bank slot select
//   RD_DATA[11:0]         combinational read of slot RD_INDEX
//   UPDATED[7:0]          sticky per-slot new-result flags
//   CLR_UPDATED[7:0]      per-slot clear strobes (a simultaneous set wins)
//   SCAN_DONE             one-cycle pulse at the end of each scan
//   TIMEOUT_ERR           sticky response-timeout flag, cleared only by reset

module mfp_adc_max10_scanner #(
  parameter int CH_FIRST     = 1,
  parameter int SCAN_PERIOD  = 5000,
  parameter int RESP_TIMEOUT = 1023
) (
  input  logic                           HCLK,
  input  logic                           HRESETn,
  input  logic                           ENABLE,
  input  logic [7:0]                     CH_MASK,
  mfp_adc_max10_scanner_if.master        adc,
  input  logic [2:0]                     RD_INDEX,
  output logic [11:0]                    RD_DATA,
  output logic [7:0]                     UPDATED,
  input  logic [7:0]                     CLR_UPDATED,
  output logic                           SCAN_DONE,
  output logic                           TIMEOUT_ERR
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SELECT,
    S_CMD,
    S_RESP,
    S_DONE
  } state_t;

  localparam int          TO_W        = $clog2(RESP_TIMEOUT + 1);
  localparam logic [19:0] PERIOD_LAST = 20'(SCAN_PERIOD - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(RESP_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  localparam logic [4:0]  CH_BASE     = 5'(CH_FIRST);
  localparam logic [5:0]  CH_LO       = 6'(CH_FIRST);
  localparam logic [5:0]  CH_HI       = 6'(CH_FIRST + 7);

  state_t            state_q, state_d;
  logic [19:0]       wait_q, wait_d;
  // ptr[3] set means the pointer has walked past slot 7
  logic [3:0]        ptr_q, ptr_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              valid_q, valid_d;
  logic [4:0]        chan_q, chan_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        updated_q;
  logic [11:0]       bank_q [8];

  logic              wr_en;
  logic [2:0]        wr_slot;
  logic [11:0]       wr_data;
  logic [7:0]        set_mask;

  logic [5:0]        r_ch6;
  logic              r_in_range;
  logic [2:0]        r_slot;
  logic              r_accept;

`ifdef MFP_ADC_MAX10_AVERAGE_EN
  logic [1:0]        samp_q, samp_d;
  logic [13:0]       sum_q, sum_d;
  logic [13:0]       acc;
`endif

  // Response decode: the slot is taken from the response channel, not the pointer.
  assign r_ch6      = {1'b0, adc.ADC_R_Channel};
  assign r_in_range = (r_ch6 >= CH_LO) && (r_ch6 <= CH_HI);
  assign r_slot     = 3'(adc.ADC_R_Channel - CH_BASE);
  assign r_accept   = adc.ADC_R_Valid && r_in_range;

`ifdef MFP_ADC_MAX10_AVERAGE_EN
  assign acc = sum_q + {2'b00, adc.ADC_R_Data};
`endif

  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    ptr_d     = ptr_q;
    tcnt_d    = tcnt_q;
    valid_d   = valid_q;
    chan_d    = chan_q;
    timeout_d = timeout_q;
    wr_en     = 1'b0;
    wr_slot   = r_slot;
    wr_data   = adc.ADC_R_Data;
    set_mask  = 8'h00;
`ifdef MFP_ADC_MAX10_AVERAGE_EN
    samp_d    = samp_q;
    sum_d     = sum_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (ENABLE) begin
          state_d = S_WAIT;
          wait_d  = 20'd0;
        end
      end

      S_WAIT: begin
        if (!ENABLE) begin
          state_d = S_IDLE;
        end else if (wait_q == PERIOD_LAST) begin
          state_d = S_SELECT;
          ptr_d   = 4'd0;
        end else begin
          wait_d = wait_q + 20'd1;
        end
      end

      // One slot examined per cycle; ENABLE low here ends the scan early.
      S_SELECT: begin
        if (!ENABLE || ptr_q[3]) begin
          state_d = S_DONE;
        end else if (CH_MASK[ptr_q[2:0]]) begin
          state_d = S_CMD;
          valid_d = 1'b1;
          chan_d  = CH_BASE + {2'b00, ptr_q[2:0]};
        end else begin
          ptr_d = ptr_q + 4'd1;
        end
      end

      // Command is held unconditionally until accepted, regardless of ENABLE.
      S_CMD: begin
        if (adc.ADC_C_Ready) begin
          valid_d = 1'b0;
          state_d = S_RESP;
          tcnt_d  = '0;
        end
      end

      // A valid response wins over a timeout landing in the same cycle.
      S_RESP: begin
        if (r_accept) begin
`ifdef MFP_ADC_MAX10_AVERAGE_EN
          if (samp_q == 2'd3) begin
            wr_en    = 1'b1;
            wr_data  = acc[13:2];
            set_mask = 8'b1 << r_slot;
            samp_d   = 2'd0;
            sum_d    = 14'd0;
            ptr_d    = ptr_q + 4'd1;
            state_d  = ENABLE ? S_SELECT : S_DONE;
          end else begin
            samp_d  = samp_q + 2'd1;
            sum_d   = acc;
            valid_d = 1'b1;
            state_d = S_CMD;
          end
`else
          wr_en    = 1'b1;
          set_mask = 8'b1 << r_slot;
          ptr_d    = ptr_q + 4'd1;
          state_d  = ENABLE ? S_SELECT : S_DONE;
`endif
        end else if (tcnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          ptr_d     = ptr_q + 4'd1;
          state_d   = ENABLE ? S_SELECT : S_DONE;
`ifdef MFP_ADC_MAX10_AVERAGE_EN
          samp_d    = 2'd0;
          sum_d     = 14'd0;
`endif
        end else begin
          tcnt_d = tcnt_q + TO_ONE;
        end
      end

      S_DONE: begin
        wait_d  = 20'd0;
        state_d = ENABLE ? S_WAIT : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= S_IDLE;
      wait_q    <= 20'd0;
      ptr_q     <= 4'd0;
      tcnt_q    <= '0;
      valid_q   <= 1'b0;
      chan_q    <= 5'd0;
      timeout_q <= 1'b0;
      updated_q <= 8'h00;
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= 12'd0;
      end
`ifdef MFP_ADC_MAX10_AVERAGE_EN
      samp_q    <= 2'd0;
      sum_q     <= 14'd0;
`endif
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      ptr_q     <= ptr_d;
      tcnt_q    <= tcnt_d;
      valid_q   <= valid_d;
      chan_q    <= chan_d;
      timeout_q <= timeout_d;
      // set has priority over a same-cycle clear
      updated_q <= (updated_q & ~CLR_UPDATED) | set_mask;
      if (wr_en) begin
        bank_q[wr_slot] <= wr_data;
      end
`ifdef MFP_ADC_MAX10_AVERAGE_EN
      samp_q    <= samp_d;
      sum_q     <= sum_d;
`endif
    end
  end

  assign adc.ADC_C_Valid   = valid_q;
  assign adc.ADC_C_Channel = chan_q;
  assign adc.ADC_C_SOP     = valid_q;
  assign adc.ADC_C_EOP     = valid_q;

  assign RD_DATA     = bank_q[RD_INDEX];
  assign UPDATED     = updated_q;
  assign SCAN_DONE   = (state_q == S_DONE);
  assign TIMEOUT_ERR = timeout_q;

  // Single-sample responses carry no framing information worth checking.
  logic unused_r_framing;
  assign unused_r_framing = adc.ADC_R_SOP ^ adc.ADC_R_EOP;

endmodule

// File: tb/tb_mfp_adc_max10_scanner.sv
// tb/tb_mfp_adc_max10_scanner.sv - scoreboard bench for mfp_adc_max10_scanner

module tb_mfp_adc_max10_scanner;

  localparam int CH_FIRST     = 1;
  localparam int SCAN_PERIOD  = 4;
  localparam int RESP_TIMEOUT = 16;
`ifdef MFP_ADC_MAX10_AVERAGE_EN
  localparam int NCONV = 4;
  localparam logic [11:0] AVG_EXP = 12'd101;
`else
  localparam int NCONV = 1;
  localparam logic [11:0] AVG_EXP = 12'd100;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic [7:0]  clr_stim = 8'h00;
  logic [7:0]  clr_bfm = 8'h00;
  logic [2:0]  rd_mon = 3'd0;
  logic [2:0]  rd_stim = 3'd0;
  logic        stim_rd_en = 1'b1;
  wire  [2:0]  rd_index = stim_rd_en ? rd_stim : rd_mon;
  wire  [7:0]  clr_updated = clr_stim | clr_bfm;
  logic [11:0] rd_data;
  logic [7:0]  updated;
  logic        scan_done;
  logic        timeout_err;

  mfp_adc_max10_scanner_if adc_if();

  mfp_adc_max10_scanner #(
    .CH_FIRST     (CH_FIRST),
    .SCAN_PERIOD  (SCAN_PERIOD),
    .RESP_TIMEOUT (RESP_TIMEOUT)
  ) dut (
    .HCLK        (clk),
    .HRESETn     (rst_n),
    .ENABLE      (enable),
    .CH_MASK     (ch_mask),
    .adc         (adc_if),
    .RD_INDEX    (rd_index),
    .RD_DATA     (rd_data),
    .UPDATED     (updated),
    .CLR_UPDATED (clr_updated),
    .SCAN_DONE   (scan_done),
    .TIMEOUT_ERR (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  slot;
    logic [11:0] value;
  } wr_t;

  logic [4:0] exp_cmd_q [$];
  wr_t        exp_wr_q [$];
  int         data_q [$];     // BFM response per command; -1 = never respond

  int ready_delay = 0;
  int resp_delay  = 3;
  bit junk_en     = 1'b0;
  bit clr_on_resp = 1'b0;
  int acc_cyc     = -100;
  int last_stall  = -1;
  int done_cnt    = 0;
  int to_seen     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_conv(input logic [4:0] ch, input int s0, input int s1, input int s2, input int s3);
    int  sm [4];
    wr_t w;
    sm = '{s0, s1, s2, s3};
    for (int k = 0; k < NCONV; k++) begin
      exp_cmd_q.push_back(ch);
      data_q.push_back(sm[k]);
    end
    w.slot  = 3'(int'(ch) - CH_FIRST);
    w.value = (NCONV == 4) ? 12'((s0 + s1 + s2 + s3) >> 2) : 12'(s0);
    exp_wr_q.push_back(w);
  endtask

  task automatic add_one(input logic [4:0] ch, input int v);
    add_conv(ch, v, v, v, v);
  endtask

  task automatic add_timeout(input logic [4:0] ch);
    exp_cmd_q.push_back(ch);
    data_q.push_back(-1);
  endtask

  task automatic check_slot(input string name, input logic [2:0] idx, input logic [11:0] exp);
    stim_rd_en = 1'b1;
    rd_stim = idx;
    #1;
    check(name, rd_data, exp);
    stim_rd_en = 1'b0;
  endtask

  task automatic clear_all;
    @(negedge clk);
    clr_stim = 8'hFF;
    @(negedge clk);
    clr_stim = 8'h00;
  endtask

  // One scan: enable, wait for SCAN_DONE, drop ENABLE in that cycle so DONE -> IDLE.
  task automatic run_scan(input logic [7:0] mask, input string name);
    int guard;
    guard = 0;
    @(negedge clk);
    ch_mask = mask;
    enable  = 1'b1;
    while (!scan_done && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    enable = 1'b0;
    check({name, "_scan_done_seen"}, 32'(guard < 3000), 32'd1);
    repeat (15) @(negedge clk);
  endtask

  // ADC BFM: Ready after ready_delay stalled cycles, response resp_delay cycles later.
  initial begin
    int         stall_b;
    int         resp_wait;
    int         d;
    bit         resp_pend;
    bit         junk_now;
    logic [4:0] cur_ch;
    stall_b = 0; resp_wait = 0; resp_pend = 0; junk_now = 0; cur_ch = 5'd0;
    adc_if.ADC_C_Ready   = 1'b0;
    adc_if.ADC_R_Valid   = 1'b0;
    adc_if.ADC_R_Channel = 5'd0;
    adc_if.ADC_R_Data    = 12'd0;
    adc_if.ADC_R_SOP     = 1'b0;
    adc_if.ADC_R_EOP     = 1'b0;
    forever begin
      @(negedge clk);
      adc_if.ADC_R_Valid = 1'b0;
      clr_bfm = 8'h00;
      if (resp_pend) begin
        if (resp_wait > 0) begin
          resp_wait--;
        end else if (junk_now) begin
          junk_now = 1'b0;
          adc_if.ADC_R_Valid   = 1'b1;
          adc_if.ADC_R_Channel = 5'd9;   // just above CH_FIRST+7
          adc_if.ADC_R_Data    = 12'h777;
        end else begin
          resp_pend = 1'b0;
          if (data_q.size() > 0) begin
            d = data_q.pop_front();
            if (d >= 0) begin
              adc_if.ADC_R_Valid   = 1'b1;
              adc_if.ADC_R_Channel = cur_ch;
              adc_if.ADC_R_Data    = 12'(d);
              if (clr_on_resp) clr_bfm = 8'h01;
            end
          end
        end
      end
      if (adc_if.ADC_C_Ready) begin
        adc_if.ADC_C_Ready = 1'b0;
        stall_b   = 0;
        resp_pend = 1'b1;
        resp_wait = resp_delay;
        junk_now  = junk_en;
      end else if (adc_if.ADC_C_Valid) begin
        if (stall_b >= ready_delay) begin
          adc_if.ADC_C_Ready = 1'b1;
          cur_ch = adc_if.ADC_C_Channel;
        end else begin
          stall_b++;
        end
      end
    end
  end

  // Monitor: samples 1 time unit after each falling edge (values seen by the next rising edge).
  initial begin
    logic       prev_stall, prev_done, prev_to;
    logic [4:0] prev_ch;
    logic [7:0] prev_upd, rise;
    logic       s_valid, s_ready, s_sop, s_eop, s_done, s_to;
    logic [4:0] s_ch;
    logic [7:0] s_upd;
    int         stall;
    wr_t        w;
    prev_stall = 0; prev_done = 0; prev_to = 0; prev_ch = 0; prev_upd = 0; stall = 0;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      #1;
      s_valid = adc_if.ADC_C_Valid;
      s_ready = adc_if.ADC_C_Ready;
      s_sop   = adc_if.ADC_C_SOP;
      s_eop   = adc_if.ADC_C_EOP;
      s_ch    = adc_if.ADC_C_Channel;
      s_upd   = updated;
      s_done  = scan_done;
      s_to    = timeout_err;

      if (prev_stall) begin
        check("cmd_hold_valid", 32'(s_valid), 32'd1);
        check("cmd_hold_channel", 32'(s_ch), 32'(prev_ch));
      end
      if (s_valid && s_ready) begin
        check("cmd_sop_eop", 32'({s_sop, s_eop}), 32'd3);
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL cmd_unexpected: got channel %0d expected no command", s_ch);
        end else begin
          check("cmd_channel", 32'(s_ch), 32'(exp_cmd_q.pop_front()));
        end
        acc_cyc    = cyc;
        last_stall = stall;
        stall      = 0;
      end else if (s_valid) begin
        stall++;
      end
      prev_stall = s_valid && !s_ready;
      prev_ch    = s_ch;

      rise = s_upd & ~prev_upd;
      for (int b = 0; b < 8; b++) begin
        if (rise[b]) begin
          if (exp_wr_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wr_unexpected: got slot %0d updated expected no write", b);
          end else begin
            w = exp_wr_q.pop_front();
            check("wr_slot", 32'(b), 32'(w.slot));
            rd_mon = 3'(b);
            #1;
            check("wr_data", 32'(rd_data), 32'(w.value));
          end
        end
      end
      prev_upd = s_upd;

      if (s_done) begin
        done_cnt++;
        check("scan_done_width", 32'(prev_done), 32'd0);
      end
      prev_done = s_done;

      // acceptance edge is the rising edge after the sample that saw Valid&&Ready
      if (s_to && !prev_to) begin
        to_seen++;
        check("timeout_latency", 32'(cyc - (acc_cyc + 1)), 32'(RESP_TIMEOUT));
      end
      prev_to = s_to;
    end
  end

  initial begin
    #1000000;
    n_errors++;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_c_valid", 32'(adc_if.ADC_C_Valid), 32'd0);
    check("rst_c_channel", 32'(adc_if.ADC_C_Channel), 32'd0);
    check("rst_c_sop_eop", 32'({adc_if.ADC_C_SOP, adc_if.ADC_C_EOP}), 32'd0);
    check("rst_updated", 32'(updated), 32'd0);
    check("rst_scan_done", 32'(scan_done), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    for (int i = 0; i < 8; i++) check_slot("rst_bank", 3'(i), 12'd0);

    // basic scan: slots 0 and 2 -> channels 1 and 3
    add_one(5'd1, 12'hA11);
    add_one(5'd3, 12'hB33);
    run_scan(8'h05, "basic");
    check("basic_updated", 32'(updated), 32'h05);
    check_slot("basic_slot0", 3'd0, 12'hA11);
    check_slot("basic_slot1", 3'd1, 12'd0);
    check_slot("basic_slot2", 3'd2, 12'hB33);
    check("basic_no_timeout", 32'(timeout_err), 32'd0);
    clear_all();

    // Ready held low for 10 cycles
    ready_delay = 10;
    add_one(5'd2, 12'h2C2);
    run_scan(8'h02, "stall");
    check("stall_cycles", 32'(last_stall), 32'd10);
    check("stall_updated", 32'(updated), 32'h02);
    ready_delay = 0;
    clear_all();

    // slot 0 never answered, slot 1 still converted
    add_timeout(5'd1);
    add_one(5'd2, 12'h3D3);
    run_scan(8'h03, "timeout");
    check("timeout_err_set", 32'(timeout_err), 32'd1);
    check("timeout_updated", 32'(updated), 32'h02);
    check_slot("timeout_slot0_kept", 3'd0, 12'hA11);
    check_slot("timeout_slot1", 3'd1, 12'h3D3);
    clear_all();

    // clear strobe coincident with the write: set wins
    clr_on_resp = 1'b1;
    add_one(5'd1, 12'h4E4);
    run_scan(8'h01, "clr_collide");
    clr_on_resp = 1'b0;
    check("clr_collide_updated", 32'(updated), 32'h01);
    check_slot("clr_collide_slot0", 3'd0, 12'h4E4);
    clear_all();

    // ENABLE dropped while the command is pending; out-of-range response ignored
    ready_delay = 5;
    junk_en = 1'b1;
    add_one(5'd2, 12'h5F5);
    guard = 0;
    @(negedge clk);
    ch_mask = 8'h06;
    enable  = 1'b1;
    while (!adc_if.ADC_C_Valid && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    enable = 1'b0;
    check("drop_cmd_seen", 32'(guard < 1000), 32'd1);
    guard = 0;
    while (!scan_done && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drop_scan_done_seen", 32'(guard < 1000), 32'd1);
    repeat (30) @(negedge clk);
    check("drop_updated", 32'(updated), 32'h02);
    check_slot("drop_slot1", 3'd1, 12'h5F5);
    check_slot("drop_slot2_kept", 3'd2, 12'hB33);
    ready_delay = 0;
    junk_en = 1'b0;
    clear_all();

    // extreme slots and sample values
    add_one(5'd1, 12'h001);
    add_one(5'd8, 12'hFFF);
    run_scan(8'h81, "edges");
    check("edges_updated", 32'(updated), 32'h81);
    check_slot("edges_slot0", 3'd0, 12'h001);
    check_slot("edges_slot7", 3'd7, 12'hFFF);
    clear_all();

    // empty mask: scan completes with no command
    run_scan(8'h00, "empty");
    check("empty_updated", 32'(updated), 32'h00);

    // averaging vector
    add_conv(5'd1, 100, 101, 102, 103);
    run_scan(8'h01, "avg");
    check_slot("avg_slot0", 3'd0, AVG_EXP);
    clear_all();

    repeat (5) @(negedge clk);
    check("end_cmd_queue_empty", 32'(exp_cmd_q.size()), 32'd0);
    check("end_wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check("end_data_queue_empty", 32'(data_q.size()), 32'd0);
    check("end_scan_done_count", 32'(done_cnt), 32'd8);
    check("end_timeout_rises", 32'(to_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
